mul_line_engine: RTL and testbench

//  Batch multiplier engine. Accepts one 512-bit cache line of up to NUM_PAIRS operand pairs.

---
 rtl/mul_line_engine.sv | 102 ++++++++++
 tb/tb_mul_line_engine.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mul_line_engine.sv
// mul_line_engine: batch multiplier taking one 512-bit line of operand pairs and returning one result line
module mul_line_engine #(
    parameter int DATA_LEN       = 32,
    parameter int NUM_PAIRS      = 8,
    parameter int PIPELINE_STAGE = 2,
    parameter int CE_DIV         = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_line,
    input  logic [4:0]   in_count,
    input  logic         in_signed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] out_line,
    output logic         busy
);
    localparam int DL = DATA_LEN;
    localparam int PS = PIPELINE_STAGE;
    localparam int CW = CE_DIV > 1 ? $clog2(CE_DIV) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_n;

    logic [CW-1:0]           ce_cnt;
    logic                    ce, accept, capture, ovf;
    logic [511:0]            line_q;
    logic [4:0]              cnt_q, cap_cnt, cnt_in;
    logic                    sgn_q;
    logic [3:0]              iss_k;
    logic [NUM_PAIRS*DL-1:0] res_q;
    logic [15:0]             ovf_q;
    logic                    p_v    [PS];
    logic [3:0]              p_idx  [PS];
    logic [2*DL-1:0]         p_prod [PS];
    logic [DL-1:0]           op_a, op_b, lo, hi;
    logic [2*DL-1:0]         prod;

    assign ce        = ce_cnt == CW'(CE_DIV - 1);
    assign in_ready  = state == IDLE && !reset && !flush;
    assign accept    = in_valid && in_ready;
    assign cnt_in    = in_count > 5'(NUM_PAIRS) ? 5'(NUM_PAIRS) : in_count;
    assign op_a      = line_q[32'(iss_k) * 2 * DL +: DL];
    assign op_b      = line_q[(32'(iss_k) * 2 + 1) * DL +: DL];
    // Extending both operands to full width makes the truncated product correct for either signedness
    assign prod      = (sgn_q ? {{DL{op_a[DL-1]}}, op_a} : {{DL{1'b0}}, op_a})
                     * (sgn_q ? {{DL{op_b[DL-1]}}, op_b} : {{DL{1'b0}}, op_b});
    assign lo        = p_prod[PS-1][DL-1:0];
    assign hi        = p_prod[PS-1][2*DL-1:DL];
    assign ovf       = sgn_q ? hi != {DL{lo[DL-1]}} : hi != '0;
    assign capture   = ce && p_v[PS-1];
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_line  = state == DONE ? 512'({res_q, ovf_q, 3'b0, cnt_q, 8'h01}) : '0;

    always_comb begin
        state_n = state;
        if (state == IDLE && accept) state_n = cnt_in == 5'd0 ? DONE : ISSUE;
        if (state == ISSUE && ce && {1'b0, iss_k} == cnt_q - 5'd1) state_n = DRAIN;
        if (state == DRAIN && capture && cap_cnt + 5'd1 == cnt_q) state_n = DONE;
        if (state == DONE && out_ready) state_n = IDLE;
    end

    always_ff @(posedge clk)
        state <= (reset || flush) ? IDLE : state_n;

    always_ff @(posedge clk) begin
        ce_cnt <= (reset || ce) ? '0 : ce_cnt + 1'b1;
        if (accept) begin
            line_q  <= in_line;
            cnt_q   <= cnt_in;
            sgn_q   <= in_signed;
            res_q   <= '0;
            ovf_q   <= '0;
            iss_k   <= '0;
            cap_cnt <= '0;
        end
        if (state == ISSUE && ce) iss_k <= iss_k + 1'b1;
        if (ce) begin
            p_v[0]    <= state == ISSUE;
            p_idx[0]  <= iss_k;
            p_prod[0] <= prod;
            for (int s = 1; s < PS; s++) begin
                p_v[s]    <= p_v[s-1];
                p_idx[s]  <= p_idx[s-1];
                p_prod[s] <= p_prod[s-1];
            end
        end
        if (capture) begin
            res_q[32'(p_idx[PS-1]) * DL +: DL] <= lo;
            ovf_q[p_idx[PS-1]]                 <= ovf;
            cap_cnt                            <= cap_cnt + 5'd1;
        end
        if (reset || flush) begin
            for (int s = 0; s < PS; s++) p_v[s] <= 1'b0;
            cap_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_mul_line_engine.sv
// tb_mul_line_engine: directed vectors against a CE_DIV=1 and a CE_DIV=3 engine sharing one input bus
module tb_mul_line_engine;
    logic         clk = 1'b0;
    logic         reset, flush, out_ready, in_sg;
    logic [1:0]   iv, ir, ov, bz;
    logic [511:0] in_line;
    logic [4:0]   in_cnt;
    logic [511:0] ol [2];
    int           passed = 0, total = 0;
    int           lat;
    logic [511:0] t1_in, t1_exp, l2, e2, l3, e3s, e3u;

    always #5 clk = ~clk;

    mul_line_engine #(.DATA_LEN(32), .NUM_PAIRS(8), .PIPELINE_STAGE(2), .CE_DIV(1)) u0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_line(in_line), .in_count(in_cnt), .in_signed(in_sg), .out_valid(ov[0]),
        .out_ready(out_ready), .out_line(ol[0]), .busy(bz[0]));

    mul_line_engine #(.DATA_LEN(32), .NUM_PAIRS(8), .PIPELINE_STAGE(2), .CE_DIV(3)) u1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_line(in_line), .in_count(in_cnt), .in_signed(in_sg), .out_valid(ov[1]),
        .out_ready(out_ready), .out_line(ol[1]), .busy(bz[1]));

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic accept(input int s, input logic [511:0] l, input logic [4:0] c, input logic sg);
        @(negedge clk);
        in_line = l;
        in_cnt  = c;
        in_sg   = sg;
        iv[s]   = 1'b1;
        #1 check("in_ready_idle", 512'(ir[s]), 512'(1));
        @(posedge clk);
        #1 iv[s] = 1'b0;
    endtask

    task automatic wait_out(input int s, output int n);
        n = 1;
        while (!ov[s] && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic take(input int s, input string tag, input logic [511:0] exp);
        check(tag, ol[s], exp);
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("in_ready_hs_clk", 512'(ir[s]), 512'(0));
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("out_valid_after_hs", 512'(ov[s]), 512'(0));
        check("in_ready_after_hs", 512'(ir[s]), 512'(1));
    endtask

    initial begin
        logic seen;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0; iv = '0;
        in_line = '0; in_cnt = '0; in_sg = 1'b0;
        t1_in = '0; t1_exp = '0;
        for (int k = 0; k < 8; k++) begin
            t1_in[64*k +: 32]       = 32'(k + 1);
            t1_in[64*k + 32 +: 32]  = 32'd3;
            t1_exp[32 + 32*k +: 32] = 32'(3 * (k + 1));
        end
        t1_exp[31:0] = 32'h0000_0801;
        l2 = '0; l2[63:0] = {32'h0001_0000, 32'h0001_0000};
        e2 = '0; e2[63:0] = {32'h0000_0000, 32'h0001_0101};
        l3 = '0; l3[63:0] = {32'd7, 32'hFFFF_FFFD};
        e3s = '0; e3s[63:0] = {32'hFFFF_FFEB, 32'h0000_0101};
        e3u = '0; e3u[63:0] = {32'hFFFF_FFEB, 32'h0001_0101};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 512'(ir[0]), 512'(0));
        check("rst_out_valid", 512'(ov[0]), 512'(0));
        check("rst_out_line", ol[0], 512'(0));
        check("rst_busy", 512'(bz[0]), 512'(0));
        reset = 1'b0;

        accept(0, t1_in, 5'd8, 1'b0);
        check("t1_busy", 512'(bz[0]), 512'(1));
        wait_out(0, lat);
        check("t1_latency", 512'(lat), 512'(11));
        take(0, "t1_line", t1_exp);

        accept(0, l2, 5'd1, 1'b0);
        wait_out(0, lat);
        take(0, "t2_line", e2);

        accept(0, l3, 5'd1, 1'b1);
        wait_out(0, lat);
        take(0, "t3_signed", e3s);
        accept(0, l3, 5'd1, 1'b0);
        wait_out(0, lat);
        take(0, "t3_unsigned", e3u);

        accept(0, t1_in, 5'd0, 1'b0);
        wait_out(0, lat);
        check("t4_zero_latency", 512'(lat), 512'(1));
        take(0, "t4_zero_line", 512'h01);
        accept(0, t1_in, 5'd12, 1'b0);
        wait_out(0, lat);
        check("t4_clamp_latency", 512'(lat), 512'(11));
        take(0, "t4_clamp_line", t1_exp);

        accept(0, t1_in, 5'd8, 1'b0);
        wait_out(0, lat);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold_valid", 512'(ov[0]), 512'(1));
            check("t5_hold_line", ol[0], t1_exp);
            check("t5_hold_in_ready", 512'(ir[0]), 512'(0));
        end
        take(0, "t5_line", t1_exp);

        accept(0, t1_in, 5'd8, 1'b0);
        repeat (3) @(posedge clk);
        #1 flush = 1'b1;
        #1 check("t6_in_ready_flush", 512'(ir[0]), 512'(0));
        @(posedge clk);
        #1 flush = 1'b0;
        check("t6_busy_after_flush", 512'(bz[0]), 512'(0));
        #1 check("t6_in_ready_after_flush", 512'(ir[0]), 512'(1));
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 seen = seen | ov[0];
        end
        check("t6_no_out_valid", 512'(seen), 512'(0));
        accept(0, t1_in, 5'd8, 1'b0);
        wait_out(0, lat);
        check("t6_rerun_latency", 512'(lat), 512'(11));
        take(0, "t6_rerun_line", t1_exp);

        accept(1, t1_in, 5'd8, 1'b0);
        wait_out(1, lat);
        check("t6_cediv3_latency_bound", 512'(lat <= 34 && ov[1]), 512'(1));
        take(1, "t6_cediv3_line", t1_exp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
